// File: rtl/audio_engine_pkg.sv
// Shared types for the polyphonic audio engine: waveform select and sequencer states.
package audio_engine_pkg;

    typedef enum logic [1:0] {
        WAVE_OFF    = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_SQUARE = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: the carry out of an offset-binary accumulator is the bitstream.
module sigma_delta_dac #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic                dac_o
);

    localparam logic [SAMPLE_W-1:0] SIGN_BIT = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [SAMPLE_W-1:0] acc_q;
    logic                dac_q;
    logic [SAMPLE_W:0]   sum_d;

    always_comb begin
        sum_d = {1'b0, acc_q} + {1'b0, sample_i ^ SIGN_BIT};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            dac_q <= 1'b0;
        end else begin
            acc_q <= sum_d[SAMPLE_W-1:0];
            dac_q <= sum_d[SAMPLE_W];
        end
    end

    assign dac_o = dac_q;

endmodule

// File: rtl/audio_engine_poly.sv
// Polyphonic oscillator engine: voices are summed one per cycle each frame, saturated,
// and fed to a sigma-delta DAC, with heartbeat, clip and activity LEDs.
module audio_engine_poly
    import audio_engine_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_W   = 16,
    parameter int SAMPLE_DIV = 256,
    parameter int MIX_SHIFT  = 2,
    parameter int HB_LOG2    = 12,
    parameter int CLIP_HOLD  = 1 << 20,
    localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [VOICE_W-1:0]  cfg_voice,
    input  logic [PHASE_W-1:0]  cfg_inc,
    input  logic [1:0]          cfg_wave,
    input  logic                cfg_sync,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                dac_out,
    output logic                led1,
    output logic                led2,
    output logic                led8
);

    localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int HB_W   = (HB_LOG2 > 0) ? HB_LOG2 : 1;
    localparam int HOLD_W = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;

    localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [VOICE_W-1:0]  VOICE_LAST = VOICE_W'(NUM_VOICES - 1);
    localparam logic [HB_W-1:0]     HB_LAST    = HB_W'((1 << HB_LOG2) - 1);
    localparam logic [SAMPLE_W-1:0] SIGN_BIT   = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] SQ_POS     = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SQ_NEG     = SIGN_BIT | SAMPLE_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_q;
    logic [VOICE_W-1:0]    vcnt_q;
    logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]    inc_q   [NUM_VOICES];
    wave_t                 wave_q  [NUM_VOICES];
    logic signed [SUM_W-1:0] acc_q;
    logic [SAMPLE_W-1:0]   sample_q;
    logic                  sample_valid_q;
    logic [HB_W-1:0]       hb_q;
    logic                  led1_q;
    logic [HOLD_W-1:0]     hold_q;
    logic                  led8_q;

    logic                  frame_start;
    logic                  cfg_hit;
    logic [SAMPLE_W-1:0]   cur_p;
    logic [SAMPLE_W-1:0]   cur_val;
    logic signed [SUM_W-1:0] cur_ext;
    logic signed [SUM_W-1:0] shifted;
    logic [SAMPLE_W-1:0]   sat_val;
    logic                  clip;
    logic                  any_active;

    function automatic logic [SAMPLE_W-1:0] wave_value(input wave_t w,
                                                       input logic [SAMPLE_W-1:0] p);
        logic [SAMPLE_W-1:0] u;
        logic [SAMPLE_W-1:0] r;
        u = p << 1;
        r = '0;
        unique case (w)
            WAVE_SAW:    r = p ^ SIGN_BIT;
            WAVE_SQUARE: r = p[SAMPLE_W-1] ? SQ_NEG : SQ_POS;
            WAVE_TRI:    r = (p[SAMPLE_W-1] ? ~u : u) ^ SIGN_BIT;
            default:     r = '0;
        endcase
        return r;
    endfunction

    assign frame_start = (tick_q == '0);
    assign cfg_ready   = (state_q == ST_IDLE);
    assign cfg_hit     = cfg_valid && cfg_ready && (int'(cfg_voice) < NUM_VOICES);

    always_comb begin
        cur_p   = phase_q[vcnt_q][PHASE_W-1 -: SAMPLE_W];
        cur_val = wave_value(wave_q[vcnt_q], cur_p);
        cur_ext = {{(SUM_W-SAMPLE_W){cur_val[SAMPLE_W-1]}}, cur_val};
        shifted = acc_q >>> MIX_SHIFT;
        clip    = 1'b0;
        sat_val = shifted[SAMPLE_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[SAMPLE_W-1:0];
            clip    = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[SAMPLE_W-1:0];
            clip    = 1'b1;
        end
    end

    always_comb begin
        any_active = 1'b0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (wave_q[i] != WAVE_OFF && inc_q[i] != '0) any_active = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (frame_start) state_d = ST_ACCUM;
            ST_ACCUM:  if (vcnt_q == VOICE_LAST) state_d = ST_OUTPUT;
            ST_OUTPUT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q         <= '0;
            vcnt_q         <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            hb_q           <= '0;
            led1_q         <= 1'b0;
            hold_q         <= '0;
            led8_q         <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
                wave_q[i]  <= WAVE_OFF;
            end
        end else begin
            tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;

            // Voice updates only happen in ACCUM and config writes only in IDLE, so they never collide.
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        acc_q  <= '0;
                        vcnt_q <= '0;
                    end
                end
                ST_ACCUM: begin
                    phase_q[vcnt_q] <= phase_q[vcnt_q] + inc_q[vcnt_q];
                    acc_q           <= acc_q + cur_ext;
                    vcnt_q          <= vcnt_q + 1'b1;
                end
                ST_OUTPUT: sample_q <= sat_val;
                default: ;
            endcase

            if (cfg_hit) begin
                inc_q[cfg_voice]  <= cfg_inc;
                wave_q[cfg_voice] <= wave_t'(cfg_wave);
                if (cfg_sync) phase_q[cfg_voice] <= '0;
            end

            sample_valid_q <= (state_q == ST_OUTPUT);

            if (state_q == ST_OUTPUT && clip) hold_q <= HOLD_W'(CLIP_HOLD);
            else if (hold_q != '0)            hold_q <= hold_q - 1'b1;

            if (sample_valid_q) begin
                if (hb_q == HB_LAST) begin
                    hb_q   <= '0;
                    led1_q <= ~led1_q;
                end else begin
                    hb_q <= hb_q + 1'b1;
                end
            end

            led8_q <= any_active;
        end
    end

    sigma_delta_dac #(.SAMPLE_W(SAMPLE_W)) u_dac (
        .clk      (clk),
        .rst      (rst),
        .sample_i (sample_q),
        .dac_o    (dac_out)
    );

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign led1         = led1_q;
    assign led2         = (hold_q != '0);
    assign led8         = led8_q;

endmodule

// File: doc/audio_engine_poly.md
AUDIO_ENGINE_POLY -- requirements
Module: audio_engine_poly

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_VOICES, 4: voices, at least 1.
- PHASE_W, 24: phase accumulator width.
- SAMPLE_W, 16: signed sample width, at most PHASE_W.
- SAMPLE_DIV, 256: clocks per sample frame, at least NUM_VOICES+3.
- MIX_SHIFT, 2: arithmetic right shift applied to the voice sum.
- HB_LOG2, 12: led1 toggles every 2^HB_LOG2 frames.
- CLIP_HOLD, 2^20: cycles led2 stays high after a clip.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- cfg_valid, in, 1: configuration write request.
- cfg_ready, out, 1: a write is accepted when cfg_valid and cfg_ready are both high.
- cfg_voice, in, max(1,clog2(NUM_VOICES)): target voice.
- cfg_inc, in, PHASE_W: phase increment per frame.
- cfg_wave, in, 2: waveform select.
- cfg_sync, in, 1: zero the target voice's phase on accept.
- sample, out, SAMPLE_W signed: mixed output sample.
- sample_valid, out, 1: one-cycle strobe marking a new sample.
- dac_out, out, 1: first-order sigma-delta bitstream.
- led1, out, 1: heartbeat.
- led2, out, 1: clip indicator.
- led8, out, 1: at least one voice is active.

Function
REQ-003 A tick counter counts 0..SAMPLE_DIV-1 and wraps; the frame-start cycle is the cycle in which it equals 0.
REQ-004 The FSM has three states: IDLE, ACCUM and OUTPUT.
- IDLE to ACCUM at frame start.
- ACCUM lasts exactly NUM_VOICES cycles; in cycle k it processes voice k.
- Then OUTPUT for one cycle, then IDLE.
REQ-005 Voice processing in ACCUM:
- Waveform is taken from the pre-increment phase; p = phase[PHASE_W-1 -: SAMPLE_W].
- phase <= (phase + inc) mod 2^PHASE_W.
- The waveform value is added to a signed accumulator of SAMPLE_W+clog2(NUM_VOICES)+1 bits, cleared at frame start.
REQ-006 Waveforms (cfg_wave encoding):
- OFF = 0: output 0; the phase still advances.
- SAW = 1: p with its MSB inverted.
- SQUARE = 2: +(2^(SAMPLE_W-1)-1) if the p MSB is 0, else -(2^(SAMPLE_W-1)-1).
- TRI = 3: u = (p<<1) when the MSB is 0, else ~(p<<1), truncated to SAMPLE_W bits; output = u with its MSB inverted.
REQ-007 OUTPUT mixing:
- sum >>> MIX_SHIFT, saturated to the signed SAMPLE_W range, is registered to sample.
- A clip is any case where saturation changed the value.
REQ-008 sample_valid is high for exactly one cycle, NUM_VOICES+2 cycles after the frame-start cycle (frame start is cycle 0); sample holds its value until the next update.
REQ-009 cfg_ready = (state == IDLE).
- A write accepted in the frame-start cycle applies to the current frame.
- While cfg_ready is low, cfg_valid is held and the write is not lost.
REQ-010 On accept, cfg_inc and cfg_wave are written to voice cfg_voice; if cfg_sync = 1, that voice's phase is set to 0.
- A cfg_voice value of NUM_VOICES or more is accepted and ignored.
REQ-011 Sigma-delta DAC:
- Updates every clock.
- {carry, acc} = acc + (sample with its MSB inverted), with acc SAMPLE_W bits wide.
- dac_out <= carry.
REQ-012 led1 toggles on every 2^HB_LOG2-th sample_valid.
REQ-013 A clip reloads a hold counter with CLIP_HOLD; led2 = (counter != 0).
REQ-014 led8 is registered: OR over all voices of (wave != OFF and inc != 0).

Reset
REQ-015 While rst is high:
- All phases, increments and the tick counter are 0; all waves are OFF; state is IDLE.
- sample = 0 and sample_valid = 0.
- The DAC accumulator, dac_out, led1, led2, led8 and the hold counter are all 0.
REQ-016 rst asserted mid-frame aborts the frame: no sample_valid is produced for it. The first frame start is the first cycle after rst deasserts.

Structure
REQ-017 A shared package audio_engine_pkg holds wave_t (WAVE_OFF, WAVE_SAW, WAVE_SQUARE, WAVE_TRI) and the FSM state enum.
REQ-018 The DAC is a sub-module, sigma_delta_dac, parametrised by SAMPLE_W; the voice registers are arrays indexed by voice number.

Verification
REQ-019 All scenarios use NUM_VOICES=4, PHASE_W=24, SAMPLE_W=16, SAMPLE_DIV=16 and MIX_SHIFT=0 unless stated otherwise.
- Reset, no configuration: sample_valid first appears 6 cycles after rst deasserts, then every 16 cycles; sample = 0; dac_out alternates 0,1; led8 = 0.
- Voice 0 SAW, inc = 0x100000: successive samples are -32768, -28672, ... in +4096 steps, wrapping after 16 frames; led8 = 1.
- Voices 0 and 1 SQUARE, inc = 0: sum 65534 saturates to sample = 32767; led2 goes high. With MIX_SHIFT=1, sample = 32767 and led2 stays low.
- cfg_valid raised during ACCUM: cfg_ready is low until IDLE; the write is accepted exactly once and first affects the next frame.
- cfg_sync on a running SAW voice: its next contribution is -32768.
- rst pulsed in the second ACCUM cycle: no sample_valid for that frame; all outputs read 0; normal framing restarts.
